// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl
//   Sequencer for the accumulator core. A start command clears the
//   accumulator, streams a contiguous block of operands from a
//   synchronous-read operand memory into it, waits for the accumulator
//   pipeline to drain, then latches the final sum and pulses done.
//
// Ports
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   start_i       start pulse, honoured only in IDLE
//   base_i        first operand address, captured with start_i
//   len_i         operand count 0..2^AWIDTH (larger values clamp), captured with start_i
//   idle_o        high while in IDLE
//   done_o        one-cycle pulse when result_o is updated
//   result_o      last completed sum, held until the next completion
//   mem_ce_o      operand memory read enable
//   mem_addr_o    operand memory read address
//   mem_q_i       operand memory read data, valid the cycle after mem_ce_o
//   acc_run_o     accumulator clear strobe (core run_i)
//   acc_valid_o   accumulator operand valid (core valid_i)
//   acc_number_o  accumulator operand (core number_i)
//   acc_result_i  accumulator running sum (core result_o)
module acc_seq_ctrl #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = 16,
  parameter int AWIDTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [AWIDTH-1:0]        base_i,
  input  logic [AWIDTH:0]          len_i,
  output logic                     idle_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     mem_ce_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
  output logic                     acc_run_o,
  output logic                     acc_valid_o,
  output logic [IN_DATA_WIDTH-1:0] acc_number_o,
  input  logic [DWIDTH-1:0]        acc_result_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  // Largest legal operand count: the whole memory.
  localparam logic [AWIDTH:0] LEN_MAX = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] LEN_ONE = {{AWIDTH{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;      // next fetch address
  logic [AWIDTH:0]     cnt_q, cnt_d;        // operands still to fetch
  logic                drain_q, drain_d;    // second DRAIN cycle marker
  logic [DWIDTH-1:0]   result_q, result_d;
  logic                acc_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      result_q    <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      result_q    <= result_d;
      // Read data arrives one cycle after the enable, so valid is the
      // enable delayed by one cycle.
      acc_valid_q <= mem_ce_o;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    result_d  = result_q;
    idle_o    = 1'b0;
    done_o    = 1'b0;
    mem_ce_o  = 1'b0;
    acc_run_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idle_o = 1'b1;
        if (start_i) begin
          addr_d  = base_i;
          cnt_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_run_o = 1'b1;
        drain_d   = 1'b0;
        state_d   = (cnt_q != '0) ? S_FETCH : S_DRAIN;
      end
      S_FETCH: begin
        mem_ce_o = 1'b1;
        // Address wraps naturally at the top of the memory.
        addr_d   = addr_q + 1'b1;
        cnt_d    = cnt_q - LEN_ONE;
        if (cnt_q == LEN_ONE) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        // Two cycles cover the last read plus the core's add latency.
        if (drain_q) begin
          result_d = acc_result_i;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result_o     = result_q;
  assign mem_addr_o   = addr_q;
  assign acc_valid_o  = acc_valid_q;
  // Forced zero keeps the core's trailing extra add from changing the sum.
  assign acc_number_o = acc_valid_q ? mem_q_i : '0;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
module tb_acc_seq_ctrl;
  localparam int IW = 8;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MEMN = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [AW:0]   len_i = '0;
  logic          idle_o, done_o, mem_ce_o, acc_run_o, acc_valid_o;
  logic [DW-1:0] result_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_q_i, acc_number_o;
  logic [DW-1:0] acc_result_i;

  acc_seq_ctrl #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .idle_o(idle_o), .done_o(done_o), .result_o(result_o),
    .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_q_i(mem_q_i),
    .acc_run_o(acc_run_o), .acc_valid_o(acc_valid_o), .acc_number_o(acc_number_o),
    .acc_result_i(acc_result_i)
  );

  always #5 clk = ~clk;

  // Operand memory: synchronous read, output holds when not enabled.
  logic [IW-1:0] mem [MEMN];
  logic [IW-1:0] mem_q = '0;
  always @(posedge clk) if (mem_ce_o) mem_q <= mem[mem_addr_o];
  assign mem_q_i = mem_q;

  // Accumulator core: clear on run, add on valid and once more after valid falls.
  logic [DW-1:0] core_acc = '0;
  logic          valid_d1 = 1'b0;
  always @(posedge clk) begin
    valid_d1 <= acc_valid_o;
    if (acc_run_o) core_acc <= '0;
    else if (acc_valid_o || valid_d1) core_acc <= core_acc + DW'(acc_number_o);
  end
  assign acc_result_i = core_acc;

  int checks = 0;
  int failures = 0;
  longint exp_prev = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Runs one job from start to done and checks it against the reference:
  // sum of the clamped block modulo 2^DW, latency N+4, address sequence.
  task automatic run_job(input string tag, input int base, input int len, input bit pulse);
    int n, c, done_cyc, runs, ces, overlap, idle_bad, addr_bad, vbad, held_bad;
    longint expsum;
    n = (len > MEMN) ? MEMN : len;
    expsum = 0;
    for (int i = 0; i < n; i++) expsum += mem[(base + i) % MEMN];
    expsum = expsum % (64'd1 << DW);
    @(negedge clk);
    chk({tag, "_idle_before"}, idle_o, 1);
    start_i = 1'b1;
    base_i  = AW'(base);
    len_i   = (AW+1)'(len);
    @(negedge clk);
    start_i = 1'b0;
    c = 1; done_cyc = -1; runs = 0; ces = 0; overlap = 0;
    idle_bad = 0; addr_bad = 0; vbad = 0; held_bad = 0;
    while (c <= n + 14) begin
      if (acc_run_o) runs++;
      if (acc_run_o && acc_valid_o) overlap++;
      if (idle_o) idle_bad++;
      if (mem_ce_o) begin
        if (int'(mem_addr_o) != (base + ces) % MEMN || c < 2 || c > n + 1) addr_bad++;
        ces++;
      end
      if (acc_valid_o && (c < 3 || c > n + 2)) vbad++;
      if (!done_o && longint'(result_o) != exp_prev) held_bad++;
      if (pulse && c == 3) begin
        start_i = 1'b1;
        base_i  = AW'($urandom_range(0, MEMN - 1));
        len_i   = (AW+1)'($urandom_range(1, 300));
      end
      if (c == 4) start_i = 1'b0;
      if (done_o) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    start_i = 1'b0;
    chk({tag, "_latency"}, done_cyc, n + 4);
    chk({tag, "_result"}, result_o, expsum);
    chk({tag, "_ce_count"}, ces, n);
    chk({tag, "_addr_seq"}, addr_bad, 0);
    chk({tag, "_valid_win"}, vbad, 0);
    chk({tag, "_run_pulses"}, runs, 1);
    chk({tag, "_run_valid_overlap"}, overlap, 0);
    chk({tag, "_idle_busy"}, idle_bad, 0);
    chk({tag, "_result_held"}, held_bad, 0);
    exp_prev = expsum;
  endtask

  initial begin
    for (int i = 0; i < MEMN; i++) mem[i] = IW'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", idle_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_ce", mem_ce_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_run", acc_run_o, 0);
    chk("rst_valid", acc_valid_o, 0);
    chk("rst_number", acc_number_o, 0);
    reset = 1'b0;

    run_job("ramp4", 0, 4, 1'b0);
    chk("ramp4_sum", exp_prev, 6);

    mem[8'hFE] = 8'd1; mem[8'hFF] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd4;
    run_job("wrap", 'hFE, 4, 1'b0);
    chk("wrap_sum", exp_prev, 10);

    run_job("len0", 'h10, 0, 1'b0);
    chk("len0_sum", exp_prev, 0);

    for (int i = 0; i < MEMN; i++) mem[i] = 8'hFF;
    run_job("full", 0, 256, 1'b0);
    chk("full_sum", exp_prev, 'hFF00);
    run_job("clamp", 0, 300, 1'b0);
    chk("clamp_sum", exp_prev, 'hFF00);

    for (int i = 0; i < MEMN; i++) mem[i] = IW'($urandom_range(0, 255));
    run_job("restart_ign", 'h20, 6, 1'b1);
    run_job("b2b_a", 'h40, 2, 1'b0);
    run_job("b2b_b", 'h50, 3, 1'b0);

    for (int j = 0; j < 6; j++) begin
      int b, l;
      for (int i = 0; i < MEMN; i++) mem[i] = IW'($urandom_range(0, 255));
      b = $urandom_range(0, MEMN - 1);
      l = $urandom_range(0, 300);
      run_job("rand", b, l, (l >= 2) && ($urandom_range(0, 1) == 1));
    end

    // Abort a len=10 job in the middle of FETCH.
    @(negedge clk);
    start_i = 1'b1; base_i = 8'h30; len_i = 9'd10;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_fetch", mem_ce_o, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_idle", idle_o, 1);
    chk("abort_done", done_o, 0);
    chk("abort_result", result_o, 0);
    chk("abort_ce", mem_ce_o, 0);
    chk("abort_run", acc_run_o, 0);
    chk("abort_valid", acc_valid_o, 0);
    chk("abort_number", acc_number_o, 0);
    reset = 1'b0;
    exp_prev = 0;
    run_job("after_abort", 'h07, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_seq_ctrl.md
# acc_seq_ctrl

Sequencer for the accumulator core. On a start command it clears the accumulator and streams a contiguous block of operands from a synchronous-read operand memory into it. It then waits for the accumulator pipeline to drain, latches the final sum and pulses done. It sits between the top-level control registers and the accumulator core.

## Interface
- IN_DATA_WIDTH, 8: operand width (memory data, accumulator input)
- DWIDTH, 16: accumulator result width
- AWIDTH, 8: operand memory address width (2^AWIDTH entries)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- base_i  in  AWIDTH  first operand address; captured with start_i
- len_i  in  AWIDTH+1  operand count, 0..2^AWIDTH; captured with start_i
- idle_o  out  1  1 in IDLE
- done_o  out  1  1-cycle pulse when result_o updated
- result_o  out  DWIDTH  last completed sum; held until next completion
- mem_ce_o  out  1  memory read enable
- mem_addr_o  out  AWIDTH  memory read address
- mem_q_i  in  IN_DATA_WIDTH  memory read data, valid the cycle after mem_ce_o
- acc_run_o  out  1  accumulator clear (run_i of core)
- acc_valid_o  out  1  accumulator operand valid (valid_i of core)
- acc_number_o  out  IN_DATA_WIDTH  accumulator operand (number_i of core)
- acc_result_i  in  DWIDTH  accumulator result (result_o of core)

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, DONE.
- IDLE: start_i=1 captures base_i and len_i. len_i values above 2^AWIDTH clamp to 2^AWIDTH. FSM goes to CLEAR.
- CLEAR (1 cycle): acc_run_o=1. Next state is FETCH if len>0, else DRAIN.
- FETCH (len cycles): mem_ce_o=1, mem_addr_o = base + i for i = 0..len-1, modulo 2^AWIDTH (wraps 0xFF→0x00). FSM leaves after the cycle with i = len-1.
- acc_valid_o is registered mem_ce_o, i.e. mem_ce_o delayed 1 cycle.
- acc_number_o = mem_q_i when acc_valid_o=1, else 0. The core performs one extra add on the cycle after valid falls, and this forced zero makes that extra add harmless.
- DRAIN (2 cycles): no memory access. At the end of the 2nd cycle, acc_result_i is latched into result_o.
- DONE (1 cycle): done_o=1, then return to IDLE.
- start_i outside IDLE is ignored; there is no queueing.
- Width: the sum is DWIDTH bits. With the defaults the maximum is 255×256 = 65280, so there is no overflow. Other parameter sets wrap modulo 2^DWIDTH, which the controller does not detect.
- reset: FSM returns to IDLE, counters clear, result_o=0, and all strobes deassert. A job in flight is abandoned. The accumulator's stale contents are harmless because every job starts with CLEAR.

## Timing
- Reset values: idle_o=1, done_o=0, result_o=0, mem_ce_o=0, mem_addr_o=0, acc_run_o=0, acc_valid_o=0, acc_number_o=0.
- Take start_i high in cycle 0.
  - Cycle 1: CLEAR, acc_run_o=1.
  - Cycles 2..N+1: FETCH with mem_ce_o=1.
  - Cycles 3..N+2: acc_valid_o=1.
  - Cycles N+2..N+3: DRAIN.
  - Cycle N+4: DONE, with done_o=1 and the new result_o visible.
- Start-to-done latency is N+4 cycles; for N=0 it is 4 cycles, with result 0.
- idle_o is low from cycle 1 through cycle N+4. The earliest next start is cycle N+5.
- acc_run_o never overlaps acc_valid_o.

## Test plan
- Memory[i]=i; start with base=0, len=4 → done_o at cycle 8 with result_o=6. mem_addr_o steps 0,1,2,3 over cycles 2..5.
- base=0xFE, len=4, with mem[0xFE]=1, mem[0xFF]=2, mem[0]=3, mem[1]=4 → addresses wrap FE,FF,00,01 and result_o=10.
- len=0 → acc_run_o pulses once, mem_ce_o never asserts, done_o at cycle 4, result_o=0.
- All 256 entries =0xFF, base=0, len=256 → result_o=0xFF00 at cycle 260. A second start with len=300 clamps to 256 and gives the same result.
- start_i pulsed again during FETCH → ignored; result and latency are unchanged. Back-to-back jobs (len=2 then len=3, 2nd started the cycle after done) → each result is independent, with no carry-over.
- reset asserted during FETCH of a len=10 job → the next cycle shows idle_o=1, all strobes 0 and result_o=0. A fresh len=2 job then returns the correct sum.
